// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-stream program loader feeding the processor program/data memory
//
// Receives a count byte N (0 means 2^ADDR_W) followed by N big-endian 16-bit
// words, writes them to consecutive addresses starting at START_ADDR, and holds
// the processor in reset for the whole load.
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   When defined, one checksum byte follows the data. The count, data and
//   checksum bytes must sum to 0x00 modulo 256; otherwise the load ends in
//   ERROR and the processor stays in reset.
//
// Ports:
//   clock, reset           rising-edge clock, asynchronous active-high reset
//   start                  single-cycle load request (IDLE, DONE or ERROR only)
//   rx_data/valid/ready    byte stream; transfer on rx_valid && rx_ready
//   mem_we/addr/data       memory write port, one mem_we cycle per word
//   cpu_reset              processor reset, active-high
//   busy, done, error      load status; done/error sticky until next start

module prog_loader #(
  parameter int                ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_data,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_HI    = 3'd2,
    S_LO    = 3'd3,
    S_WRITE = 3'd4,
`ifdef LOADER_CHECKSUM_EN
    S_CSUM  = 3'd5,
`endif
    S_DONE  = 3'd6,
    S_ERROR = 3'd7
  } state_t;

  // A count byte of zero stands for a full 2^ADDR_W-word image.
  localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};

  state_t          state, state_next;
  logic [ADDR_W:0] remaining;
  logic            accept;
  logic            start_take;
  logic            busy_next;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum_acc;
  logic [7:0] csum_final;
  assign csum_final = csum_acc + rx_data;
`endif

  assign accept = rx_valid && rx_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    rx_ready   = 1'b0;
    mem_we     = 1'b0;
    start_take = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_next = S_COUNT;
          start_take = 1'b1;
        end
      end
      S_COUNT: begin
        rx_ready = 1'b1;
        if (rx_valid) state_next = S_HI;
      end
      S_HI: begin
        rx_ready = 1'b1;
        if (rx_valid) state_next = S_LO;
      end
      S_LO: begin
        rx_ready = 1'b1;
        if (rx_valid) state_next = S_WRITE;
      end
      S_WRITE: begin
        mem_we = 1'b1;
        if (remaining == {{ADDR_W{1'b0}}, 1'b1}) begin
`ifdef LOADER_CHECKSUM_EN
          state_next = S_CSUM;
`else
          state_next = S_DONE;
`endif
        end else begin
          state_next = S_HI;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        rx_ready = 1'b1;
        if (rx_valid) state_next = (csum_final == 8'h00) ? S_DONE : S_ERROR;
      end
`endif
      default: state_next = S_IDLE;
    endcase
  end

  assign busy_next = (state_next != S_IDLE) && (state_next != S_DONE) &&
                     (state_next != S_ERROR);

  // Status outputs are registered from the next state so they line up with
  // the state they describe; ERROR keeps the processor in reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_addr  <= START_ADDR;
      mem_data  <= 16'h0000;
      remaining <= '0;
      cpu_reset <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_acc  <= 8'h00;
`endif
    end else begin
      busy      <= busy_next;
      cpu_reset <= busy_next || (state_next == S_ERROR);
      done      <= (state_next == S_DONE);
      if (start_take) begin
        mem_addr <= START_ADDR;
`ifdef LOADER_CHECKSUM_EN
        csum_acc <= 8'h00;
`endif
      end
      case (state)
        S_COUNT: if (accept) begin
          remaining <= (rx_data == 8'h00) ? FULL_COUNT : (ADDR_W+1)'(rx_data);
`ifdef LOADER_CHECKSUM_EN
          csum_acc  <= csum_final;
`endif
        end
        S_HI: if (accept) begin
          mem_data[15:8] <= rx_data;
`ifdef LOADER_CHECKSUM_EN
          csum_acc       <= csum_final;
`endif
        end
        S_LO: if (accept) begin
          mem_data[7:0] <= rx_data;
`ifdef LOADER_CHECKSUM_EN
          csum_acc      <= csum_final;
`endif
        end
        S_WRITE: begin
          mem_addr  <= mem_addr + 1'b1;
          remaining <= remaining - 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic error_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) error_q <= 1'b0;
    else       error_q <= (state_next == S_ERROR);
  end
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed self-checking bench for prog_loader
module tb_prog_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;

  logic        rx_ready0, mem_we0, cpu_reset0, busy0, done0, error0;
  logic [7:0]  mem_addr0;
  logic [15:0] mem_data0;
  logic        rx_ready1, mem_we1, cpu_reset1, busy1, done1, error1;
  logic [7:0]  mem_addr1;
  logic [15:0] mem_data1;

  prog_loader #(.ADDR_W(8), .START_ADDR(8'h00)) dut0 (
    .clock(clock), .reset(reset), .start(start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready0),
    .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_data(mem_data0),
    .cpu_reset(cpu_reset0), .busy(busy0), .done(done0), .error(error0)
  );

  prog_loader #(.ADDR_W(8), .START_ADDR(8'hFE)) dut1 (
    .clock(clock), .reset(reset), .start(start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready1),
    .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_data(mem_data1),
    .cpu_reset(cpu_reset1), .busy(busy1), .done(done1), .error(error1)
  );

  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0]  wa0 [0:511];
  logic [15:0] wd0 [0:511];
  logic [7:0]  wa1 [0:511];
  logic [15:0] wd1 [0:511];
  logic [15:0] mem0 [0:255];
  int          wn0 = 0;
  int          wn1 = 0;
  int          we_rdy_bad = 0;
  int          busy_gap_bad = 0;
  bit          watch_busy = 1'b0;
  logic [7:0]  csum;

  always @(posedge clock) begin
    if (mem_we0) begin
      if (wn0 < 512) begin
        wa0[wn0] <= mem_addr0;
        wd0[wn0] <= mem_data0;
      end
      mem0[mem_addr0] <= mem_data0;
      wn0 <= wn0 + 1;
      if (rx_ready0) we_rdy_bad <= we_rdy_bad + 1;
    end
    if (mem_we1) begin
      if (wn1 < 512) begin
        wa1[wn1] <= mem_addr1;
        wd1[wn1] <= mem_data1;
      end
      wn1 <= wn1 + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    for (int i = 0; i < gap; i++) begin
      rx_valid = 1'b0;
      @(negedge clock);
      if (watch_busy && !busy0) busy_gap_bad++;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    #1;
    t = 0;
    while (!rx_ready0 && t < 200) begin
      @(negedge clock);
      #1;
      t++;
    end
    if (t >= 200) begin
      chk("rx_timeout", t, 0);
    end else begin
      @(posedge clock);
      csum = csum + b;
      @(negedge clock);
    end
    rx_valid = 1'b0;
  endtask

  task automatic start_load();
    start = 1'b1;
    csum  = 8'h00;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic finish_load();
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00 - csum, 0);
`else
    @(negedge clock);
`endif
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int base0, base1, mism;

  initial begin
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; csum = 8'h00;
    repeat (3) @(negedge clock);
    chk("rst_cpu_reset", cpu_reset0, 1);
    chk("rst_mem_we", mem_we0, 0);
    chk("rst_mem_addr0", mem_addr0, 8'h00);
    chk("rst_mem_addr1", mem_addr1, 8'hFE);
    chk("rst_mem_data", mem_data0, 16'h0000);
    chk("rst_rx_ready", rx_ready0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_error", error0, 0);
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_cpu_reset", cpu_reset0, 0);

    // Basic load; start and a valid byte in the same IDLE cycle.
    start = 1'b1; rx_valid = 1'b1; rx_data = 8'h02; csum = 8'h00;
    #1;
    chk("idle_rx_ready", rx_ready0, 0);
    @(negedge clock);
    start = 1'b0;
    chk("count_busy", busy0, 1);
    chk("count_cpu_reset", cpu_reset0, 1);
    chk("count_rx_ready", rx_ready0, 1);
    send_byte(8'h02, 0);
    send_byte(8'h02, 0); send_byte(8'h05, 0);
    send_byte(8'h00, 0); send_byte(8'h07, 0);
    chk("w2_mem_we", mem_we0, 1);
    chk("w2_mem_addr", mem_addr0, 8'h01);
    chk("w2_mem_data", mem_data0, 16'h0007);
    chk("w2_rx_ready", rx_ready0, 0);
    finish_load();
    chk("basic_done", done0, 1);
    chk("basic_cpu_reset", cpu_reset0, 0);
    chk("basic_busy", busy0, 0);
    chk("basic_nwrites", wn0, 2);
    chk("basic_a0", wa0[0], 8'h00);
    chk("basic_d0", wd0[0], 16'h0205);
    chk("basic_a1", wa0[1], 8'h01);
    chk("basic_d1", wd0[1], 16'h0007);
    chk("basic_dut1_a0", wa1[0], 8'hFE);

    // Same stream with 4-cycle gaps between bytes.
    base0 = wn0;
    start_load();
    watch_busy = 1'b1;
    send_byte(8'h02, 4);
    send_byte(8'h02, 4); send_byte(8'h05, 4);
    send_byte(8'h00, 4); send_byte(8'h07, 4);
    watch_busy = 1'b0;
    finish_load();
    chk("bp_nwrites", wn0 - base0, 2);
    chk("bp_a0", wa0[base0], 8'h00);
    chk("bp_d0", wd0[base0], 16'h0205);
    chk("bp_a1", wa0[base0+1], 8'h01);
    chk("bp_d1", wd0[base0+1], 16'h0007);
    chk("bp_busy_gaps", busy_gap_bad, 0);
    chk("bp_done", done0, 1);

    // Start pulse during HI is ignored.
    base0 = wn0;
    start_load();
    send_byte(8'h01, 0);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("hi_start_busy", busy0, 1);
    send_byte(8'h12, 0); send_byte(8'h34, 0);
    finish_load();
    chk("hi_start_done", done0, 1);
    chk("hi_start_nwrites", wn0 - base0, 1);
    chk("hi_start_d0", wd0[base0], 16'h1234);

    // Full 256-word image; the 0xFE instance wraps through the top.
    base1 = wn1;
    start_load();
    send_byte(8'h00, 0);
    for (int i = 0; i < 256; i++) begin
      send_byte(8'(i), 0);
      send_byte(8'(i) ^ 8'h5A, 0);
    end
    finish_load();
    chk("wrap_done", done1, 1);
    chk("wrap_nwrites", wn1 - base1, 256);
    mism = 0;
    for (int k = 0; k < 256; k++) begin
      if (wa1[base1+k] !== 8'(8'hFE + k)) mism++;
      if (wd1[base1+k] !== {8'(k), 8'(k) ^ 8'h5A}) mism++;
    end
    chk("wrap_mismatches", mism, 0);

    // Start in DONE re-asserts cpu_reset next cycle.
    start_load();
    chk("redo_cpu_reset", cpu_reset0, 1);
    chk("redo_done", done0, 0);
    chk("redo_busy", busy0, 1);

    // Reset after the first word is written.
    send_byte(8'h02, 0); send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    @(negedge clock);
    chk("mid_word_written", mem0[0], 16'hAABB);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy0, 0);
    chk("mid_rst_mem_we", mem_we0, 0);
    chk("mid_rst_done", done0, 0);
    chk("mid_rst_cpu_reset", cpu_reset0, 1);
    chk("mid_rst_rx_ready", rx_ready0, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("mid_post_cpu_reset", cpu_reset0, 0);
    chk("mid_post_busy", busy0, 0);
    chk("mid_mem_kept", mem0[0], 16'hAABB);

`ifdef LOADER_CHECKSUM_EN
    start_load();
    send_byte(8'h01, 0); send_byte(8'h12, 0); send_byte(8'h34, 0);
    send_byte(8'hB9, 0);
    chk("cs_pass_done", done0, 1);
    chk("cs_pass_error", error0, 0);
    chk("cs_pass_cpu_reset", cpu_reset0, 0);
    start_load();
    send_byte(8'h01, 0); send_byte(8'h12, 0); send_byte(8'h34, 0);
    send_byte(8'hB8, 0);
    chk("cs_fail_error", error0, 1);
    chk("cs_fail_done", done0, 0);
    chk("cs_fail_cpu_reset", cpu_reset0, 1);
    start_load();
    send_byte(8'h01, 0); send_byte(8'h12, 0); send_byte(8'h34, 0);
    send_byte(8'hB9, 0);
    chk("cs_retry_error", error0, 0);
    chk("cs_retry_cpu_reset", cpu_reset0, 0);
    chk("cs_retry_done", done0, 1);
`else
    chk("no_cs_error", error0, 0);
`endif

    chk("write_ready_overlap", we_rdy_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Byte-stream program loader sitting directly upstream of the processor's single-port program/data memory. It receives a word count followed by big-endian 16-bit words on a valid/ready byte interface, writes each word into consecutive memory addresses, and holds the processor in reset for the whole load. When the load completes it releases the processor, which then starts fetching from address 0.

## Interface
- ADDR_W, 8: memory address width; also sets the maximum word count to 2^ADDR_W.
- START_ADDR, 0: address of the first word written.
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader accepts a byte this cycle; a transfer occurs on a rising edge with rx_valid && rx_ready.
- mem_we  out  1  memory write enable, one cycle per word.
- mem_addr  out  ADDR_W  memory write address.
- mem_data  out  16  memory write data.
- cpu_reset  out  1  reset to the processor, active-high.
- busy  out  1  load in progress.
- done  out  1  last load completed successfully; sticky until the next start or reset.
- error  out  1  last load failed its checksum; sticky until the next start or reset.

## Operation
- States:
  - IDLE: cpu_reset=0. On start, go to COUNT.
  - COUNT: rx_ready=1. Accept the count byte N into remaining; N=0 means 2^ADDR_W words. Go to HI.
  - HI: rx_ready=1. Accept the byte into mem_data[15:8]. Go to LO.
  - LO: rx_ready=1. Accept the byte into mem_data[7:0]. Go to WRITE.
  - WRITE: rx_ready=0, mem_we=1. Then mem_addr increments and remaining decrements.
    - If remaining becomes 0: go to CSUM when the checksum feature is compiled in, otherwise DONE.
    - Otherwise return to HI.
  - CSUM: rx_ready=1. Accept the checksum byte. Go to DONE on pass, ERROR on fail.
  - DONE: done=1, cpu_reset=0.
  - ERROR: error=1, cpu_reset=1.
- On start, mem_addr is loaded with START_ADDR, and done, error and the checksum accumulator are cleared.
- busy=1 and cpu_reset=1 in COUNT, HI, LO, WRITE and CSUM.
- start while busy is ignored.
- start in DONE or ERROR begins a new load.
- A start in DONE asserts cpu_reset again from the next cycle.
- rx_ready=0 in IDLE, DONE and ERROR. Bytes offered there are not consumed.
- Address arithmetic is modulo 2^ADDR_W. With START_ADDR≠0 and a large N, addresses wrap past the top to 0.
- remaining is ADDR_W+1 bits wide so that the full count 2^ADDR_W fits.

## Timing
- Reset values:
  - state=IDLE
  - cpu_reset=1 (drops to 0 on the first clock edge after reset deasserts)
  - mem_we=0, mem_addr=START_ADDR, mem_data=0
  - rx_ready=0, busy=0, done=0, error=0
- All outputs are registered except rx_ready and mem_we, which decode the current state.
- Best-case throughput is 3 cycles per word (HI, LO, WRITE) when rx_valid is held high.
- Minimum load time is 1 + 3N cycles from the first accepted byte, plus 1 cycle with the checksum feature.
- mem_addr and mem_data are stable for the whole WRITE cycle. The write lands on the rising edge that ends WRITE.
- start and rx_valid in the same IDLE cycle: start is taken and the byte is not consumed. The byte is accepted in COUNT on the next cycle if still valid.
- Gaps in rx_valid stall the loader in the current state indefinitely; there is no timeout.
- Reset asserted mid-load:
  - return to IDLE immediately;
  - already-written words stay in memory;
  - cpu_reset stays 1 while reset is asserted, then drops to 0.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - CSUM state present; one extra byte follows the data.
  - The 8-bit accumulator sums the count byte, all data bytes and the checksum byte modulo 256.
  - Pass when the final sum is 0x00, otherwise ERROR.
  - In ERROR the processor stays in reset until a new load passes or reset is asserted.
- LOADER_CHECKSUM_EN undefined:
  - no CSUM state and no accumulator;
  - WRITE of the last word goes straight to DONE;
  - error is tied to 0.

## Test plan
- Basic load, macro off: start, then stream 0x02, 0x02,0x05, 0x00,0x07 with rx_valid always 1 → mem_we pulses at addr 0x00 data 0x0205 and addr 0x01 data 0x0007. done=1 and cpu_reset=0 one cycle after the second WRITE; rx_ready is low in every WRITE cycle.
- Backpressure and stalls: same stream with rx_valid low for 4 cycles between every byte → identical writes, nothing lost or duplicated, busy=1 throughout.
- Full count with wrap, START_ADDR=0xFE: count byte 0x00 followed by 512 bytes → 256 writes at 0xFE, 0xFF, 0x00…0xFD, then done=1.
- Checksum, macro on: stream 0x01, 0x12,0x34 with checksum 0xB9 → done=1. Same stream with checksum 0xB8 → error=1, done=0, cpu_reset=1; a subsequent correct load clears error and releases cpu_reset.
- Start while busy: pulse start during HI → ignored, load completes normally. A start in DONE → cpu_reset=1 next cycle, done=0.
- Reset mid-load: assert reset after the first word is written → state IDLE, mem_we=0, busy=0, done=0, cpu_reset=1 during reset then 0. The first word remains in memory.
